// File: rtl/level_sequencer.sv
// Game-flow sequencer: picks the live level, holds all other levels in reset,
// and steps through win/lose holds, lives, game over and victory.
module level_sequencer #(
  parameter int NUM_LEVELS   = 3,
  parameter int START_LIVES  = 3,
  parameter int PAUSE_CYCLES = 50_000_000,
  parameter int RESET_CYCLES = 4,
  localparam int SEL_W   = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int LIVES_W = (START_LIVES > 1) ? $clog2(START_LIVES + 1) : 1
) (
  input  logic                  vga_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_LEVELS-1:0] level_win,
  input  logic [NUM_LEVELS-1:0] level_lose,
  output logic [NUM_LEVELS-1:0] level_reset_n,
  output logic [SEL_W-1:0]      level_select,
  output logic [LIVES_W-1:0]    lives,
  output logic [2:0]            state,
  output logic                  game_over,
  output logic                  victory
);

  // state     | meaning
  // TITLE     | attract screen, every level held in reset
  // LOAD      | selected level held in reset for RESET_CYCLES
  // PLAY      | selected level live, its win/lose flags watched
  // WIN_HOLD  | result frozen on screen, then next level or victory
  // LOSE_HOLD | result frozen on screen, then retry or game over
  // GAME_OVER | end screen, start begins a new game
  // VICTORY   | end screen, start begins a new game

  localparam int PAUSE_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam int LOAD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [PAUSE_W-1:0] PAUSE_TC   = PAUSE_W'(PAUSE_CYCLES - 1);
  localparam logic [LOAD_W-1:0]  LOAD_TC    = LOAD_W'(RESET_CYCLES - 1);
  localparam logic [SEL_W-1:0]   LAST_SEL   = SEL_W'(NUM_LEVELS - 1);
  localparam logic [LIVES_W-1:0] FULL_LIVES = LIVES_W'(START_LIVES);

  typedef enum logic [2:0] {
    S_TITLE     = 3'd0,
    S_LOAD      = 3'd1,
    S_PLAY      = 3'd2,
    S_WIN_HOLD  = 3'd3,
    S_LOSE_HOLD = 3'd4,
    S_GAME_OVER = 3'd5,
    S_VICTORY   = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [LIVES_W-1:0]    lives_q, lives_d;
  logic [PAUSE_W-1:0]    pause_cnt;
  logic [LOAD_W-1:0]     load_cnt;
  logic                  start_s1, start_s2, start_s3;
  logic                  start_pulse;
  logic                  win_sel, lose_sel;
  logic                  level_live;
  logic [NUM_LEVELS-1:0] reset_n_d;

  assign start_pulse = start_s2 & ~start_s3;
  assign win_sel     = level_win[sel_q];
  assign lose_sel    = level_lose[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    lives_d = lives_q;
    case (state_q)
      S_TITLE: begin
        if (start_pulse) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (load_cnt == LOAD_TC) state_d = S_PLAY;
      end
      S_PLAY: begin
        // win wins a same-cycle tie with lose
        if (win_sel) begin
          state_d = S_WIN_HOLD;
        end else if (lose_sel) begin
          state_d = S_LOSE_HOLD;
          if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
        end
      end
      S_WIN_HOLD: begin
        if (pause_cnt == PAUSE_TC) begin
          if (sel_q == LAST_SEL) begin
            state_d = S_VICTORY;
          end else begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_LOSE_HOLD: begin
        if (pause_cnt == PAUSE_TC) state_d = (lives_q == '0) ? S_GAME_OVER : S_LOAD;
      end
      S_GAME_OVER, S_VICTORY: begin
        if (start_pulse) begin
          sel_d   = '0;
          lives_d = FULL_LIVES;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_TITLE;
    endcase
  end

  // Level resets follow the registered state, so they lag a transition by one cycle.
  always_comb begin
    level_live = (state_q == S_PLAY) || (state_q == S_WIN_HOLD) || (state_q == S_LOSE_HOLD);
    reset_n_d  = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      reset_n_d[i] = level_live && (sel_q == SEL_W'(i));
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_TITLE;
      sel_q         <= '0;
      lives_q       <= FULL_LIVES;
      pause_cnt     <= '0;
      load_cnt      <= '0;
      start_s1      <= 1'b0;
      start_s2      <= 1'b0;
      start_s3      <= 1'b0;
      level_reset_n <= '0;
      game_over     <= 1'b0;
      victory       <= 1'b0;
    end else begin
      start_s1      <= start;
      start_s2      <= start_s1;
      start_s3      <= start_s2;
      state_q       <= state_d;
      sel_q         <= sel_d;
      lives_q       <= lives_d;
      load_cnt      <= (state_q == S_LOAD && state_d == S_LOAD) ? load_cnt + LOAD_W'(1) : '0;
      pause_cnt     <= ((state_q == S_WIN_HOLD || state_q == S_LOSE_HOLD) && state_d == state_q)
                       ? pause_cnt + PAUSE_W'(1) : '0;
      level_reset_n <= reset_n_d;
      game_over     <= (state_d == S_GAME_OVER);
      victory       <= (state_d == S_VICTORY);
    end
  end

  assign state        = state_q;
  assign level_select = sel_q;
  assign lives        = lives_q;

endmodule
